// File: rtl/fetch_prefetch_buffer_if.sv
// Fetch-side bus: redirect input, instruction-memory request/response, and the decode handshake.
// With FETCH_PERF_EN defined, the bus also carries the perf_fetched and perf_dropped counters.
interface fetch_prefetch_buffer_if #(
    parameter int XLEN = 32
);
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_valid;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]     perf_fetched;
    logic [31:0]     perf_dropped;
`endif

    modport master (
        input  redirect_valid, redirect_pc, imem_ready, imem_valid, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_instr
`ifdef FETCH_PERF_EN
        , output perf_fetched, perf_dropped
`endif
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_ready, imem_valid, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_instr
`ifdef FETCH_PERF_EN
        , input perf_fetched, perf_dropped
`endif
    );
endinterface

// File: rtl/fetch_prefetch_buffer.sv
// Prefetching fetch stage: credit-limited sequential requests, in-order response FIFO, redirect flush.
// The FETCH_PERF_EN macro adds the perf_fetched and perf_dropped counters.
module fetch_prefetch_buffer #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                    clk,
    input logic                    rst,
    fetch_prefetch_buffer_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [PW-1:0] ptr_t;

    logic [XLEN-1:0] fetch_pc, resp_pc;
    cnt_t            count, inflight, discard;
    ptr_t            wr_ptr, rd_ptr;
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [CW:0] credits_used;
    logic        issue, accept, resp, push, pop;
    logic        redirect;

    assign redirect     = bus.redirect_valid;
    assign credits_used = {1'b0, inflight} + {1'b0, count};
    // Requests are held off while in reset so nothing is issued before the PC is valid.
    assign issue        = rst && !redirect && (credits_used < (CW + 1)'(DEPTH));
    assign accept       = issue && bus.imem_ready;
    // A response with nothing outstanding is a protocol error and is ignored entirely.
    assign resp         = bus.imem_valid && (inflight != '0);
    assign push         = resp && !redirect && (discard == '0);
    assign pop          = bus.out_valid && bus.out_ready && !redirect;

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = (count != '0);
    assign bus.out_pc    = bus.out_valid ? pc_mem[rd_ptr] : '0;
    assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= inflight + cnt_t'(accept) - cnt_t'(resp);
            if (redirect) begin
                // Everything still outstanding after this cycle belongs to the old stream.
                fetch_pc <= bus.redirect_pc & ~XLEN'(3);
                resp_pc  <= bus.redirect_pc & ~XLEN'(3);
                count    <= '0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                discard  <= inflight - cnt_t'(resp);
            end else begin
                if (accept) fetch_pc <= fetch_pc + XLEN'(4);
                if (push) begin
                    resp_pc <= resp_pc + XLEN'(4);
                    wr_ptr  <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                if (resp && discard != '0) discard <= discard - cnt_t'(1);
                count <= count + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // NOTE: the entry storage is deliberately not reset; out_* are gated by out_valid,
    // so an unwritten or flushed slot can never reach decode.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= resp_pc;
            instr_mem[wr_ptr] <= bus.imem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q, perf_dropped_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
        end else begin
            perf_fetched_q <= perf_fetched_q + 32'(bus.out_valid && bus.out_ready);
            perf_dropped_q <= perf_dropped_q + 32'(resp && !push);
        end
    end

    assign bus.perf_fetched = perf_fetched_q;
    assign bus.perf_dropped = perf_dropped_q;
`endif
endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for fetch_prefetch_buffer with a 1-cycle memory model and an in-order pop scoreboard.
module tb_fetch_prefetch_buffer;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_prefetch_buffer_if #(.XLEN(XLEN)) bus ();

    fetch_prefetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   acc_count = 0;
    bit   mem_hold  = 1'b0;
    req_t pending[$];
    exp_t sb[$];

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Memory model and scoreboard: samples at the falling edge, drives 2 units after the rising edge.
    initial begin : mem_model
        req_t        r;
        exp_t        e;
        logic [31:0] cur_addr;
        bit          cur_stale;
        cur_addr       = '0;
        cur_stale      = 1'b0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pending.delete();
                sb.delete();
                acc_count = 0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    check("pop_expected", {31'b0, sb.size() != 0}, 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        check("pop_pc", bus.out_pc, e.pc);
                        check("pop_instr", bus.out_instr, e.instr);
                    end
                end
                if (bus.redirect_valid) begin
                    sb.delete();
                    foreach (pending[i]) pending[i].stale = 1'b1;
                end else if (bus.imem_valid && !cur_stale) begin
                    sb.push_back('{pc: cur_addr, instr: mem_data(cur_addr)});
                end
                if (bus.imem_req && bus.imem_ready) begin
                    pending.push_back('{addr: bus.imem_addr, stale: 1'b0});
                    acc_count++;
                end
            end
            @(posedge clk);
            #2;
            bus.imem_valid = 1'b0;
            if (rst && !mem_hold && pending.size() != 0) begin
                r              = pending.pop_front();
                bus.imem_valid = 1'b1;
                bus.imem_rdata = mem_data(r.addr);
                cur_addr       = r.addr;
                cur_stale      = r.stale;
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin : stimulus
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ready     = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (2) sample();

        // Reset state
        check("rst_req", bus.imem_req, 32'd0);
        check("rst_addr", bus.imem_addr, 32'h0);
        check("rst_out_valid", bus.out_valid, 32'd0);
        check("rst_out_pc", bus.out_pc, 32'h0);
        check("rst_out_instr", bus.out_instr, 32'h0);

        // Streaming with 1-cycle memory: 2-cycle fill then one instruction per cycle
        tick(); rst = 1'b1; sample();
        check("t1_req", bus.imem_req, 32'd1);
        check("t1_addr0", bus.imem_addr, 32'h0);
        tick(); sample();
        check("t1_fill", bus.out_valid, 32'd0);
        check("t1_addr4", bus.imem_addr, 32'h4);
        for (int k = 0; k < 4; k++) begin
            tick(); sample();
            check("t1_valid", bus.out_valid, 32'd1);
            check("t1_pc", bus.out_pc, 32'(4 * k));
            check("t1_instr", bus.out_instr, mem_data(32'(4 * k)));
        end

        // Stalled decode: credits run out after DEPTH requests, head held
        tick(); rst = 1'b0; bus.out_ready = 1'b0; sample();
        tick(); rst = 1'b1; sample();
        for (int c = 1; c <= 6; c++) begin
            tick(); sample();
            if (c >= 2) begin
                check("t2_hold_pc", bus.out_pc, 32'h0);
                check("t2_hold_instr", bus.out_instr, mem_data(32'h0));
            end
            if (c >= 5) check("t2_no_req", bus.imem_req, 32'd0);
        end
        check("t2_accepted", 32'(acc_count), 32'(DEPTH));
        tick(); bus.out_ready = 1'b1; sample();
        check("t2_rel_pc0", bus.out_pc, 32'h0);
        tick(); sample();
        check("t2_rel_pc4", bus.out_pc, 32'h4);
        check("t2_resume_req", bus.imem_req, 32'd1);
        check("t2_resume_addr", bus.imem_addr, 32'h10);
        tick(); sample();
        check("t2_rel_pc8", bus.out_pc, 32'h8);
        tick(); sample();
        check("t2_rel_pc12", bus.out_pc, 32'hc);
        tick(); sample();
        check("t2_rel_pc16", bus.out_pc, 32'h10);

        // Redirect with 2 in flight and 1 buffered
        tick(); rst = 1'b0; bus.out_ready = 1'b0; sample();
        tick(); rst = 1'b1; sample();
        tick(); sample();
        tick(); mem_hold = 1'b1; sample();
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; sample();
        check("t3_redir_no_req", bus.imem_req, 32'd0);
        check("t3_redir_buffered", bus.out_valid, 32'd1);
        tick(); bus.redirect_valid = 1'b0; mem_hold = 1'b0; bus.out_ready = 1'b1; sample();
        check("t3_flushed", bus.out_valid, 32'd0);
        check("t3_new_addr", bus.imem_addr, 32'h100);
        check("t3_new_req", bus.imem_req, 32'd1);
        tick(); sample();
        check("t3_drop1", bus.out_valid, 32'd0);
        tick(); sample();
        check("t3_drop2", bus.out_valid, 32'd0);
        tick(); sample();
        check("t3_first_valid", bus.out_valid, 32'd1);
        check("t3_first_pc", bus.out_pc, 32'h100);
        check("t3_first_instr", bus.out_instr, mem_data(32'h100));

        // Unaligned redirect target is forced to word alignment
        tick(); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h103; sample();
        tick(); bus.redirect_valid = 1'b0; sample();
        check("t4_aligned_addr", bus.imem_addr, 32'h100);
        check("t4_req", bus.imem_req, 32'd1);
        check("t4_empty", bus.out_valid, 32'd0);
        tick(); sample();
        check("t4_fill", bus.out_valid, 32'd0);
        tick(); sample();
        check("t4_pc", bus.out_pc, 32'h100);

        // Redirect coincident with a response, 3 in flight
        tick(); rst = 1'b0; mem_hold = 1'b1; sample();
        tick(); rst = 1'b1; sample();
        tick(); sample();
        tick(); sample();
        tick(); mem_hold = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; sample();
        check("t5_redir_no_req", bus.imem_req, 32'd0);
        tick(); bus.redirect_valid = 1'b0; sample();
        check("t5_not_pushed", bus.out_valid, 32'd0);
        check("t5_addr", bus.imem_addr, 32'h200);
        tick(); sample();
        check("t5_drop1", bus.out_valid, 32'd0);
        tick(); sample();
        check("t5_drop2", bus.out_valid, 32'd0);
        tick(); sample();
        check("t5_first_pc", bus.out_pc, 32'h200);
        check("t5_first_instr", bus.out_instr, mem_data(32'h200));

        // Mid-stream reset with a full FIFO
        tick(); bus.out_ready = 1'b0; sample();
        repeat (8) begin tick(); sample(); end
        check("t6_full_valid", bus.out_valid, 32'd1);
        check("t6_full_no_req", bus.imem_req, 32'd0);
        tick(); rst = 1'b0; sample();
        check("t6_rst_req", bus.imem_req, 32'd0);
        check("t6_rst_addr", bus.imem_addr, 32'h0);
        check("t6_rst_valid", bus.out_valid, 32'd0);
        check("t6_rst_pc", bus.out_pc, 32'h0);
        check("t6_rst_instr", bus.out_instr, 32'h0);
`ifdef FETCH_PERF_EN
        check("t6_perf_fetched", bus.perf_fetched, 32'h0);
        check("t6_perf_dropped", bus.perf_dropped, 32'h0);
`endif
        tick(); rst = 1'b1; bus.out_ready = 1'b1; sample();
        check("t6_post_addr", bus.imem_addr, 32'h0);
        check("t6_post_req", bus.imem_req, 32'd1);
        repeat (4) begin tick(); sample(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
